gin_cfg_sched: RTL and testbench
================================

// Module: gin_cfg_sched
// PURPOSE
// - Sequencer in front of the global input network (YBus + XBuses): loads row-ID and PE-ID scan chains, then streams tagged data.
// - Config words from the host arrive on a valid/ready port; data packets are forwarded on the GIN enable/ready port.
// - One-entry output register decouples the host from GIN ready stalls.
// - Sits between the top-level controller/DMA and the GIN instance in the PE-array top.
// PARAMETERS
// - XBUS_NUMS  12  XBuses = row-chain length
// - PE_NUMS    14  PEs per XBus; ID-chain length = XBUS_NUMS*PE_NUMS
// - ID_LEN     5   col tag / PE ID width
// - ROW_LEN    4   row tag / row ID width
// - VALUE_LEN  32  payload width
// PORTS
// - clk          in   1                  single clock, rising edge
// - rst          in   1                  asynchronous, active-low reset
// - start        in   1                  pulse: begin config load (honoured in IDLE only)
// - finish       in   1                  pulse/level: leave RUN once output register empty
// - busy         out  1                  state != IDLE
// - cfg_valid    in   1                  config word valid
// - cfg_ready    out  1                  config word accepted when valid&ready
// - cfg_data     in   ID_LEN             row ID (low ROW_LEN bits) or PE ID
// - dat_valid    in   1                  data packet valid
// - dat_ready    out  1                  data packet accepted when valid&ready
// - dat_row      in   ROW_LEN            row tag
// - dat_col      in   ID_LEN             col tag
// - dat_value    in   VALUE_LEN          payload
// - gin_enable   out  1                  to GIN enable
// - gin_ready    in   1                  from GIN ready
// - gin_row_tag  out  ROW_LEN            to GIN row_tag
// - gin_col_tag  out  ID_LEN             to GIN col_tag
// - gin_value    out  VALUE_LEN          to GIN value
// - set_row      out  1                  row-chain shift strobe
// - row_scan_in  out  ROW_LEN            row-chain shift data
// - set_id       out  1                  ID-chain shift strobe
// - id_scan_in   out  ID_LEN             ID-chain shift data
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; all outputs 0; counters 0; output register empty.
// - FSM: IDLE -start-> LOAD_ROW -XBUS_NUMS words-> LOAD_ID -XBUS_NUMS*PE_NUMS words-> RUN -finish & !gin_enable-> IDLE.
// - Start/finish outside their states ignored; start and finish in same cycle in IDLE: start wins.
// - cfg_ready=1 only in LOAD_ROW/LOAD_ID. Each accepted word drives exactly one-cycle set_row (or set_id) with data on the next edge: registered, 1-cycle latency.
// - No strobe in cycles without an accepted word; chain stalls cleanly on cfg_valid gaps.
// - Word k (0-based) of the row phase ends at XBus XBUS_NUMS-1-k, i.e. first word shifted farthest. ID phase same, over all PEs.
// - Shift counter width $clog2(XBUS_NUMS*PE_NUMS+1). Last word of a phase switches state on the same edge; no bubble.
// - RUN: dat_ready = !gin_enable | gin_ready (combinational). Transfer to GIN when gin_enable & gin_ready at edge.
// - gin_* fields stable while gin_enable=1 & gin_ready=0. Back-to-back packets sustain 1/cycle. Accept latency 1 cycle.
// - dat_ready=0 outside RUN. finish with register full: hold RUN until drained, then IDLE; no new accepts after finish seen.
// - Reset mid-load leaves chains partially shifted: host must reload via start.
// CONFIGURATION
// - GIN_TXCNT_EN defined: extra port tx_count out 32, counts GIN transfers (enable&ready).
// - tx_count clears on reset and on start; wraps at 2^32.
// - GIN_TXCNT_EN undefined: port and counter absent; all else identical.
// STRUCTURE
// - Shared package gin_pkg: state enum (IDLE, LOAD_ROW, LOAD_ID, RUN).
// - gin_pkg also holds localparams ROW_CHAIN_LEN=XBUS_NUMS, ID_CHAIN_LEN=XBUS_NUMS*PE_NUMS, and packet struct {row,col,value}.
// - One natural sub-module: gin_out_reg (one-entry valid/ready register for the packet); FSM + counters in top.
// TESTING
// - Reset mid-RUN with gin_enable=1: all outputs 0 immediately; busy=0.
// - start, 12 row words 0..11 then 168 PE IDs, cfg_valid toggled every other cycle:
//   -> exactly 12 set_row then 168 set_id pulses; data in order; none during gaps.
// - Golden GIN chain model after load: XBus 11 row ID=0, XBus 0 row ID=11.
// - RUN, 4 packets back-to-back, gin_ready=1: 4 GIN transfers on 4 consecutive cycles, payload and order intact.
// - gin_ready held 0 for 5 cycles with packet pending: gin_* stable; dat_ready=0; packet sent once on release.
// - finish while register full and gin_ready=0: stays RUN until transfer, then IDLE next cycle; start in RUN ignored.
// - GIN_TXCNT_EN: 10 transfers -> tx_count=10; new start -> 0.

Source files
------------

// File: rtl/gin_pkg.sv
// Shared types and sizes for the GIN config/data sequencer.
// Holds the FSM state enum, chain lengths and the GIN packet bundle.
package gin_pkg;

    localparam int XBUS_NUMS = 12;
    localparam int PE_NUMS   = 14;
    localparam int ID_LEN    = 5;
    localparam int ROW_LEN   = 4;
    localparam int VALUE_LEN = 32;

    localparam int ROW_CHAIN_LEN = XBUS_NUMS;
    localparam int ID_CHAIN_LEN  = XBUS_NUMS * PE_NUMS;
    localparam int CNT_W         = $clog2(ID_CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_ROW,
        LOAD_ID,
        RUN
    } gin_state_e;

    typedef struct packed {
        logic [ROW_LEN-1:0]   row;
        logic [ID_LEN-1:0]    col;
        logic [VALUE_LEN-1:0] value;
    } gin_pkt_t;

endpackage

// File: rtl/gin_cfg_sched_if.sv
// Host config/data handshakes plus the GIN enable/ready port.
// master = host/controller side, slave = the sequencer.
interface gin_cfg_sched_if
    import gin_pkg::*;
();

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [ID_LEN-1:0]    cfg_data;

    logic                 dat_valid;
    logic                 dat_ready;
    logic [ROW_LEN-1:0]   dat_row;
    logic [ID_LEN-1:0]    dat_col;
    logic [VALUE_LEN-1:0] dat_value;

    logic                 gin_enable;
    logic                 gin_ready;
    logic [ROW_LEN-1:0]   gin_row_tag;
    logic [ID_LEN-1:0]    gin_col_tag;
    logic [VALUE_LEN-1:0] gin_value;

    modport master (
        output cfg_valid, cfg_data,
        output dat_valid, dat_row, dat_col, dat_value,
        output gin_ready,
        input  cfg_ready, dat_ready,
        input  gin_enable, gin_row_tag, gin_col_tag, gin_value
    );

    modport slave (
        input  cfg_valid, cfg_data,
        input  dat_valid, dat_row, dat_col, dat_value,
        input  gin_ready,
        output cfg_ready, dat_ready,
        output gin_enable, gin_row_tag, gin_col_tag, gin_value
    );

endinterface

// File: rtl/gin_out_reg.sv
// One-entry valid/ready register holding the packet offered to the GIN.
// Fields only change on accept, so they stay put while the GIN stalls.
module gin_out_reg
    import gin_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    output logic     in_ready,
    input  gin_pkt_t in_pkt,
    output logic     out_valid,
    input  logic     out_ready,
    output gin_pkt_t out_pkt
);

    logic     valid_q, valid_d;
    gin_pkt_t pkt_q, pkt_d;

    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_pkt   = pkt_q;

    // Load on accept, drop once the GIN takes the entry.
    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            pkt_d   = in_pkt;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Entry register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

endmodule

// File: rtl/gin_cfg_sched.sv
// Loads the GIN row-ID and PE-ID scan chains, then streams tagged packets.
// Optional GIN transfer counter port tx_count under GIN_TXCNT_EN.
module gin_cfg_sched
    import gin_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               finish,
    output logic               busy,
    gin_cfg_sched_if.slave     bus,
    output logic               set_row,
    output logic [ROW_LEN-1:0] row_scan_in,
`ifdef GIN_TXCNT_EN
    output logic [31:0]        tx_count,
`endif
    output logic               set_id,
    output logic [ID_LEN-1:0]  id_scan_in
);

    gin_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               set_row_q, set_row_d;
    logic [ROW_LEN-1:0] row_scan_q, row_scan_d;
    logic               set_id_q, set_id_d;
    logic [ID_LEN-1:0]  id_scan_q, id_scan_d;
    logic               fin_q, fin_d;

    logic     cfg_ready;
    logic     cfg_fire;
    logic     fin_hit;
    logic     acc_en;
    logic     reg_in_ready;
    logic     reg_out_valid;
    gin_pkt_t in_pkt;
    gin_pkt_t out_pkt;

    assign cfg_ready = (state_q == LOAD_ROW) | (state_q == LOAD_ID);
    assign cfg_fire  = bus.cfg_valid & cfg_ready;
    assign fin_hit   = fin_q | finish;
    assign acc_en    = (state_q == RUN) & !fin_hit;

    assign in_pkt.row   = bus.dat_row;
    assign in_pkt.col   = bus.dat_col;
    assign in_pkt.value = bus.dat_value;

    gin_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.dat_valid & acc_en),
        .in_ready  (reg_in_ready),
        .in_pkt    (in_pkt),
        .out_valid (reg_out_valid),
        .out_ready (bus.gin_ready),
        .out_pkt   (out_pkt)
    );

    assign busy            = state_q != IDLE;
    assign bus.cfg_ready   = cfg_ready;
    assign bus.dat_ready   = acc_en & reg_in_ready;
    assign bus.gin_enable  = reg_out_valid;
    assign bus.gin_row_tag = out_pkt.row;
    assign bus.gin_col_tag = out_pkt.col;
    assign bus.gin_value   = out_pkt.value;
    assign set_row         = set_row_q;
    assign row_scan_in     = row_scan_q;
    assign set_id          = set_id_q;
    assign id_scan_in      = id_scan_q;

    // Next state, shift counter and registered chain strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        set_row_d  = 1'b0;
        row_scan_d = row_scan_q;
        set_id_d   = 1'b0;
        id_scan_d  = id_scan_q;
        fin_d      = fin_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_ROW;
                    cnt_d   = '0;
                end
            end
            LOAD_ROW: begin
                if (cfg_fire) begin
                    set_row_d  = 1'b1;
                    row_scan_d = bus.cfg_data[ROW_LEN-1:0];
                    if (cnt_q == CNT_W'(ROW_CHAIN_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_ID;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_ID: begin
                if (cfg_fire) begin
                    set_id_d  = 1'b1;
                    id_scan_d = bus.cfg_data;
                    if (cnt_q == CNT_W'(ID_CHAIN_LEN - 1)) begin
                        cnt_d   = '0;
                        fin_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (finish) begin
                    fin_d = 1'b1;
                end
                if (fin_hit && !reg_out_valid) begin
                    fin_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, counter and chain output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            set_row_q  <= 1'b0;
            row_scan_q <= '0;
            set_id_q   <= 1'b0;
            id_scan_q  <= '0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            set_row_q  <= set_row_d;
            row_scan_q <= row_scan_d;
            set_id_q   <= set_id_d;
            id_scan_q  <= id_scan_d;
            fin_q      <= fin_d;
        end
    end

`ifdef GIN_TXCNT_EN
    logic [31:0] tx_q, tx_d;

    assign tx_count = tx_q;

    // Count GIN transfers; a honoured start clears the count.
    always_comb begin
        tx_d = tx_q;
        if (state_q == IDLE && start) begin
            tx_d = '0;
        end else if (reg_out_valid && bus.gin_ready) begin
            tx_d = tx_q + 32'd1;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q <= '0;
        end else begin
            tx_q <= tx_d;
        end
    end
`endif

endmodule

// File: tb/tb_gin_cfg_sched.sv
// Directed bench for gin_cfg_sched: chain load, streaming, stall, finish.
// Build with GIN_TXCNT_EN defined to also cover tx_count.
module tb_gin_cfg_sched;
    import gin_pkg::*;

    logic               clk;
    logic               rst;
    logic               start;
    logic               finish;
    logic               busy;
    logic               set_row;
    logic [ROW_LEN-1:0] row_scan_in;
    logic               set_id;
    logic [ID_LEN-1:0]  id_scan_in;
`ifdef GIN_TXCNT_EN
    logic [31:0]        tx_count;
`endif

    gin_cfg_sched_if bus ();

    gin_cfg_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .finish      (finish),
        .busy        (busy),
        .bus         (bus),
        .set_row     (set_row),
        .row_scan_in (row_scan_in),
`ifdef GIN_TXCNT_EN
        .tx_count    (tx_count),
`endif
        .set_id      (set_id),
        .id_scan_in  (id_scan_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Monitor state (written only by the monitor process)
    logic               mon_en = 1'b0;
    int                 acc = 0;
    int                 rows_seen = 0;
    int                 ids_seen = 0;
    int                 gap_err = 0;
    logic               pf_row = 1'b0;
    logic               pf_id = 1'b0;
    logic [ROW_LEN-1:0] rc [ROW_CHAIN_LEN];
    logic [ID_LEN-1:0]  ic [ID_CHAIN_LEN];
    int                 cyc = 0;
    gin_pkt_t           tx_log [$];
    int                 tx_cyc [$];

    always @(negedge clk) begin
        logic fire;
        cyc++;
        if (rst && bus.gin_enable && bus.gin_ready) begin
            tx_log.push_back({bus.gin_row_tag, bus.gin_col_tag, bus.gin_value});
            tx_cyc.push_back(cyc);
        end
        if (mon_en) begin
            if (set_row) begin
                rows_seen++;
                if (!pf_row) gap_err++;
                for (int k = ROW_CHAIN_LEN - 1; k > 0; k--) rc[k] = rc[k-1];
                rc[0] = row_scan_in;
            end
            if (set_id) begin
                ids_seen++;
                if (!pf_id) gap_err++;
                for (int k = ID_CHAIN_LEN - 1; k > 0; k--) ic[k] = ic[k-1];
                ic[0] = id_scan_in;
            end
            fire = bus.cfg_valid && bus.cfg_ready;
            pf_row = fire && (acc < ROW_CHAIN_LEN);
            pf_id = fire && (acc >= ROW_CHAIN_LEN);
            if (fire) acc++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, bus.cfg_ready, bus.dat_ready, bus.gin_enable,
                    bus.gin_row_tag, bus.gin_col_tag, bus.gin_value,
                    set_row, row_scan_in, set_id, id_scan_in});
    endfunction

    function automatic logic [ID_LEN-1:0] cfg_word(input int w);
        if (w < ROW_CHAIN_LEN) return ID_LEN'(w);
        return ID_LEN'(((w - ROW_CHAIN_LEN) * 7 + 3) % 32);
    endfunction

    function automatic gin_pkt_t mk_pkt(input int i);
        gin_pkt_t p;
        p.row   = ROW_LEN'(i + 3);
        p.col   = ID_LEN'(i * 5 + 1);
        p.value = 32'hA5000000 + 32'(i * 32'h1111);
        return p;
    endfunction

    task automatic drive_pkt(input gin_pkt_t p);
        bus.dat_valid = 1'b1;
        bus.dat_row   = p.row;
        bus.dat_col   = p.col;
        bus.dat_value = p.value;
    endtask

    initial begin
        int err;
        gin_pkt_t p;
        rst = 1'b0;
        start = 1'b0;
        finish = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data = '0;
        bus.dat_valid = 1'b0;
        bus.dat_row = '0;
        bus.dat_col = '0;
        bus.dat_value = '0;
        bus.gin_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset_outs", all_outs(), 64'd0);
`ifdef GIN_TXCNT_EN
        chk("reset_txcnt", 64'(tx_count), 64'd0);
`endif
        rst = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // Config load with cfg_valid toggled every other cycle
        mon_en = 1'b1;
        start = 1'b1;
        finish = 1'b1;
        tick();
        start = 1'b0;
        finish = 1'b0;
        #1;
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        chk("load_dat_ready", 64'(bus.dat_ready), 64'd0);
        for (int w = 0; w < ROW_CHAIN_LEN + ID_CHAIN_LEN; w++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data = cfg_word(w);
            tick();
            bus.cfg_valid = 1'b0;
            tick();
        end
        tick();
        chk("row_pulses", 64'(rows_seen), 64'(ROW_CHAIN_LEN));
        chk("id_pulses", 64'(ids_seen), 64'(ID_CHAIN_LEN));
        chk("gap_pulses", 64'(gap_err), 64'd0);
        chk("xbus11_row", 64'(rc[11]), 64'd0);
        chk("xbus0_row", 64'(rc[0]), 64'd11);
        err = 0;
        for (int k = 0; k < ROW_CHAIN_LEN; k++)
            if (rc[ROW_CHAIN_LEN-1-k] !== ROW_LEN'(k)) err++;
        for (int j = 0; j < ID_CHAIN_LEN; j++)
            if (ic[ID_CHAIN_LEN-1-j] !== ID_LEN'((j * 7 + 3) % 32)) err++;
        chk("chain_model", 64'(err), 64'd0);
        chk("pe_last_id", 64'(ic[0]), 64'(((ID_CHAIN_LEN - 1) * 7 + 3) % 32));
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_cfg_ready", 64'(bus.cfg_ready), 64'd0);
        mon_en = 1'b0;

        // Back-to-back packets with gin_ready high
        bus.gin_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_pkt(mk_pkt(i));
            #1;
            chk("b2b_dat_ready", 64'(bus.dat_ready), 64'd1);
            tick();
        end
        bus.dat_valid = 1'b0;
        tick();
        tick();
        chk("b2b_count", 64'(tx_log.size()), 64'd4);
        if (tx_log.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk("b2b_pkt", 64'(tx_log[i]), 64'(mk_pkt(i)));
            chk("b2b_consec", 64'(tx_cyc[3] - tx_cyc[0]), 64'd3);
        end

        // Stall with a packet pending
        bus.gin_ready = 1'b0;
        drive_pkt(mk_pkt(5));
        #1;
        chk("stall_accept", 64'(bus.dat_ready), 64'd1);
        tick();
        drive_pkt(mk_pkt(6));
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_en", 64'(bus.gin_enable), 64'd1);
            chk("stall_hold", 64'({bus.gin_row_tag, bus.gin_col_tag, bus.gin_value}),
                64'(mk_pkt(5)));
            chk("stall_dat_ready", 64'(bus.dat_ready), 64'd0);
            tick();
        end
        chk("stall_no_tx", 64'(tx_log.size()), 64'd4);
        bus.gin_ready = 1'b1;
        #1;
        chk("release_ready", 64'(bus.dat_ready), 64'd1);
        tick();
        bus.dat_valid = 1'b0;
        tick();
        tick();
        chk("release_count", 64'(tx_log.size()), 64'd6);
        if (tx_log.size() == 6) begin
            chk("release_p5", 64'(tx_log[4]), 64'(mk_pkt(5)));
            chk("release_p6", 64'(tx_log[5]), 64'(mk_pkt(6)));
        end

        // Finish while the register is full and the GIN stalls
        bus.gin_ready = 1'b0;
        drive_pkt(mk_pkt(7));
        tick();
        bus.dat_valid = 1'b0;
        finish = 1'b1;
        #1;
        chk("fin_dat_ready", 64'(bus.dat_ready), 64'd0);
        tick();
        finish = 1'b0;
        start = 1'b1;
        drive_pkt(mk_pkt(8));
        tick();
        start = 1'b0;
        #1;
        chk("fin_hold_busy", 64'(busy), 64'd1);
        chk("fin_start_ign", 64'(bus.cfg_ready), 64'd0);
        chk("fin_hold_en", 64'(bus.gin_enable), 64'd1);
        bus.gin_ready = 1'b1;
        #1;
        chk("fin_no_accept", 64'(bus.dat_ready), 64'd0);
        tick();
        chk("fin_drained", 64'(bus.gin_enable), 64'd0);
        chk("fin_still_run", 64'(busy), 64'd1);
        tick();
        chk("fin_idle", 64'(busy), 64'd0);
        bus.dat_valid = 1'b0;
        tick();
        chk("fin_count", 64'(tx_log.size()), 64'd7);
        if (tx_log.size() == 7)
            chk("fin_p7", 64'(tx_log[6]), 64'(mk_pkt(7)));

        // Reload without gaps, then stream again
`ifdef GIN_TXCNT_EN
        chk("txcnt_7", 64'(tx_count), 64'd7);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef GIN_TXCNT_EN
        chk("txcnt_clear", 64'(tx_count), 64'd0);
`endif
        bus.cfg_valid = 1'b1;
        for (int w = 0; w < ROW_CHAIN_LEN + ID_CHAIN_LEN; w++) begin
            bus.cfg_data = cfg_word(w);
            tick();
        end
        bus.cfg_valid = 1'b0;
        #1;
        chk("reload_run", 64'({busy, bus.cfg_ready, bus.dat_ready}), 64'b101);
        for (int i = 10; i < 20; i++) begin
            drive_pkt(mk_pkt(i));
            tick();
        end
        bus.dat_valid = 1'b0;
        tick();
        tick();
        chk("reload_count", 64'(tx_log.size()), 64'd17);
`ifdef GIN_TXCNT_EN
        chk("txcnt_10", 64'(tx_count), 64'd10);
`endif

        // Asynchronous reset mid-RUN with gin_enable high
        bus.gin_ready = 1'b0;
        drive_pkt(mk_pkt(21));
        tick();
        bus.dat_valid = 1'b0;
        chk("pre_rst_en", 64'(bus.gin_enable), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_outs", all_outs(), 64'd0);
`ifdef GIN_TXCNT_EN
        chk("async_rst_txcnt", 64'(tx_count), 64'd0);
`endif
        tick();
        chk("rst_hold_outs", all_outs(), 64'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
